// File: rtl/asym_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : asym_fifo_pkg
//  Description : Elaboration-time helper functions shared by the asymmetric
//                FIFO and its RAM. Used to derive the unit widths, width
//                ratio and pointer sizes.
//  Contents    : max_f()  - larger of two integers
//                min_f()  - smaller of two integers
//                log2_f() - ceiling log2 (log2_f(1) = 0)
//  Revision    : 1.0 - initial release
// ============================================================================
package asym_fifo_pkg;

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min_f(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int log2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage : asym_fifo_pkg
`default_nettype wire

// File: rtl/asym_fifo_sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : asym_fifo_sdp_ram
//  Description : Single-clock simple-dual-port RAM with different write and
//                read widths. Storage is an array of MIN_WIDTH cells. A port
//                word covers (width/MIN_WIDTH) consecutive cells, and the
//                lowest cell holds the least significant slice.
//  Ports       : clk      - clock
//                i_we     - write enable
//                i_waddr  - write address, in WR_WIDTH words
//                i_wdata  - write data
//                i_re     - read enable; o_rdata updates only when set
//                i_raddr  - read address, in RD_WIDTH words
//                o_rdata  - registered read data (1-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module asym_fifo_sdp_ram
  import asym_fifo_pkg::*;
#(
  parameter int WR_WIDTH = 8,
  parameter int RD_WIDTH = 32,
  parameter int DEPTH    = 1024,
  parameter int WA_W     = 8,
  parameter int RA_W     = 8
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [WA_W-1:0]     i_waddr,
  input  logic [WR_WIDTH-1:0] i_wdata,
  input  logic                i_re,
  input  logic [RA_W-1:0]     i_raddr,
  output logic [RD_WIDTH-1:0] o_rdata
);

  localparam int MIN_WIDTH = min_f(WR_WIDTH, RD_WIDTH);
  localparam int WU        = WR_WIDTH / MIN_WIDTH;
  localparam int RU        = RD_WIDTH / MIN_WIDTH;
  localparam int CA_W      = max_f(1, log2_f(DEPTH));

  logic [MIN_WIDTH-1:0] r_mem [DEPTH];
  logic [RD_WIDTH-1:0]  r_rdata;
  logic [CA_W-1:0]      w_wbase;
  logic [CA_W-1:0]      w_rbase;

  // Cell address of sub-word 0; equivalent to {addr, lsb} since WU/RU are
  // powers of two.
  assign w_wbase = CA_W'(i_waddr) * CA_W'(WU);
  assign w_rbase = CA_W'(i_raddr) * CA_W'(RU);

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < WU; k++) begin
        r_mem[w_wbase + CA_W'(k)] <= i_wdata[k*MIN_WIDTH +: MIN_WIDTH];
      end
    end
  end

  // Holds its value when not read, so the FIFO can use it as a skid stage.
  always_ff @(posedge clk) begin
    if (i_re) begin
      for (int k = 0; k < RU; k++) begin
        r_rdata[k*MIN_WIDTH +: MIN_WIDTH] <= r_mem[w_rbase + CA_W'(k)];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule : asym_fifo_sdp_ram
`default_nettype wire

// File: rtl/asym_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : asym_fifo
//  Description : Single-clock FIFO with different write and read widths
//                (power-of-two ratio). Sub-words pack and unpack
//                little-endian. Valid/ready on both sides. The output is a
//                first-word-fall-through register fed by a 1-cycle RAM read.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                in_valid / in_ready / in_data    - write side
//                out_valid / out_ready / out_data - read side (registered)
//                fill_level - RAM occupancy in MIN_WIDTH units
//  Revision    : 1.0 - initial release
// ============================================================================
module asym_fifo
  import asym_fifo_pkg::*;
#(
  parameter int WR_WIDTH = 8,
  parameter int RD_WIDTH = 32,
  parameter int DEPTH    = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WR_WIDTH-1:0]         in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [RD_WIDTH-1:0]         out_data,
  output logic [log2_f(DEPTH+1)-1:0]  fill_level
);

  localparam int MIN_WIDTH = min_f(WR_WIDTH, RD_WIDTH);
  localparam int MAX_WIDTH = max_f(WR_WIDTH, RD_WIDTH);
  localparam int RATIO     = MAX_WIDTH / MIN_WIDTH;
  localparam int LOG2RATIO = log2_f(RATIO);
  localparam int WU        = (WR_WIDTH > RD_WIDTH) ? (1 << LOG2RATIO) : 1;
  localparam int RU        = (RD_WIDTH > WR_WIDTH) ? (1 << LOG2RATIO) : 1;
  localparam int CNT_W     = log2_f(DEPTH + 1);
  localparam int WR_WORDS  = DEPTH / WU;
  localparam int RD_WORDS  = DEPTH / RU;
  localparam int WA_W      = max_f(1, log2_f(WR_WORDS));
  localparam int RA_W      = max_f(1, log2_f(RD_WORDS));

  typedef logic [CNT_W-1:0] fifo_cnt_t;

  logic [WA_W-1:0]     r_wr_ptr;
  logic [RA_W-1:0]     r_rd_ptr;
  fifo_cnt_t           r_fill;
  logic                r_ram_pend;   // RAM read register holds an undelivered word
  logic                r_out_valid;
  logic [RD_WIDTH-1:0] r_out_data;

  logic                w_wr_acc;
  logic                w_out_free;
  logic                w_rd_issue;
  logic                w_out_load;
  fifo_cnt_t           w_fill_next;
  logic [RD_WIDTH-1:0] w_ram_rdata;

  // Room is judged from registered occupancy only; a read this cycle does
  // not free space for a write in the same cycle.
  assign in_ready   = !rst && (r_fill <= fifo_cnt_t'(DEPTH - WU));
  assign w_wr_acc   = in_valid && in_ready;

  assign w_out_free = !r_out_valid || out_ready;
  assign w_rd_issue = (r_fill >= fifo_cnt_t'(RU)) && w_out_free;
  // A word in the RAM read register moves to the output whenever the output
  // slot frees up. An issue is only allowed under the same condition, so
  // a pending word is never overwritten before it is delivered.
  assign w_out_load = r_ram_pend && w_out_free;

  assign w_fill_next = r_fill
                     + (w_wr_acc   ? fifo_cnt_t'(WU) : fifo_cnt_t'(0))
                     - (w_rd_issue ? fifo_cnt_t'(RU) : fifo_cnt_t'(0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_ram_pend  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= (r_wr_ptr == WA_W'(WR_WORDS - 1)) ? '0 : r_wr_ptr + WA_W'(1);
      end
      if (w_rd_issue) begin
        r_rd_ptr <= (r_rd_ptr == RA_W'(RD_WORDS - 1)) ? '0 : r_rd_ptr + RA_W'(1);
      end
      r_fill     <= w_fill_next;
      r_ram_pend <= w_rd_issue || (r_ram_pend && !w_out_load);
      if (w_out_load) begin
        r_out_data  <= w_ram_rdata;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  asym_fifo_sdp_ram #(
    .WR_WIDTH (WR_WIDTH),
    .RD_WIDTH (RD_WIDTH),
    .DEPTH    (DEPTH),
    .WA_W     (WA_W),
    .RA_W     (RA_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_re    (w_rd_issue),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_rdata)
  );

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign fill_level = r_fill;

endmodule : asym_fifo
`default_nettype wire

// File: tb/tb_asym_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_asym_fifo
//  Description : Self-checking bench for asym_fifo. Three instances, all with
//                DEPTH=16: A (8->32), B (32->8) and C (16->16). Accepted
//                writes feed per-instance reference queues. Delivered reads
//                are popped from the queues and compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_asym_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]  a_in_data;
  logic [31:0] a_out_data;
  logic [4:0]  a_fill;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data;
  logic [7:0]  b_out_data;
  logic [4:0]  b_fill;

  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [15:0] c_in_data;
  logic [15:0] c_out_data;
  logic [4:0]  c_fill;

  asym_fifo #(.WR_WIDTH(8), .RD_WIDTH(32), .DEPTH(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .fill_level(a_fill));

  asym_fifo #(.WR_WIDTH(32), .RD_WIDTH(8), .DEPTH(16)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .fill_level(b_fill));

  asym_fifo #(.WR_WIDTH(16), .RD_WIDTH(16), .DEPTH(16)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .fill_level(c_fill));

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- scoreboards ----------------
  logic [31:0] a_q[$];
  logic [7:0]  b_q[$];
  logic [15:0] c_q[$];
  logic [31:0] a_pack, a_exp;
  logic [7:0]  b_exp;
  logic [15:0] c_exp;
  int          a_cnt;

  always @(negedge clk) begin
    if (rst) begin
      a_q.delete(); a_pack = '0; a_cnt = 0;
    end else begin
      if (a_in_valid && a_in_ready) begin
        a_pack[8*a_cnt +: 8] = a_in_data;
        a_cnt++;
        if (a_cnt == 4) begin a_q.push_back(a_pack); a_pack = '0; a_cnt = 0; end
      end
      if (a_out_valid && a_out_ready) begin
        n_checks++;
        if (a_q.size() == 0) begin
          n_fail++; $display("FAIL a_scoreboard_extra: got %h, expected no word", a_out_data);
        end else begin
          a_exp = a_q.pop_front();
          if (a_out_data !== a_exp) begin
            n_fail++; $display("FAIL a_scoreboard_data: got %h, expected %h", a_out_data, a_exp);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      b_q.delete();
    end else begin
      if (b_in_valid && b_in_ready)
        for (int k = 0; k < 4; k++) b_q.push_back(b_in_data[8*k +: 8]);
      if (b_out_valid && b_out_ready) begin
        n_checks++;
        if (b_q.size() == 0) begin
          n_fail++; $display("FAIL b_scoreboard_extra: got %h, expected no word", b_out_data);
        end else begin
          b_exp = b_q.pop_front();
          if (b_out_data !== b_exp) begin
            n_fail++; $display("FAIL b_scoreboard_data: got %h, expected %h", b_out_data, b_exp);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      c_q.delete();
    end else begin
      if (c_in_valid && c_in_ready) c_q.push_back(c_in_data);
      if (c_out_valid && c_out_ready) begin
        n_checks++;
        if (c_q.size() == 0) begin
          n_fail++; $display("FAIL c_scoreboard_extra: got %h, expected no word", c_out_data);
        end else begin
          c_exp = c_q.pop_front();
          if (c_out_data !== c_exp) begin
            n_fail++; $display("FAIL c_scoreboard_data: got %h, expected %h", c_out_data, c_exp);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
    b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
    c_in_valid = 0; c_out_ready = 0; c_in_data = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    a_in_valid = 1'b1; a_in_data = 8'hEE;   // must be ignored during reset
    tick(); tick();
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_in_ready: got %b expected 0", a_in_ready); end
    n_checks++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_in_ready: got %b expected 0", b_in_ready); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_out_valid: got %b expected 0", a_out_valid); end
    n_checks++; if (a_out_data !== 32'h0) begin n_fail++; $display("FAIL reset_a_out_data: got %h expected 0", a_out_data); end
    n_checks++; if (c_fill !== 5'd0) begin n_fail++; $display("FAIL reset_c_fill: got %0d expected 0", c_fill); end
    a_in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_a_in_ready: got %b expected 1", a_in_ready); end
    n_checks++; if (c_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_c_in_ready: got %b expected 1", c_in_ready); end
    n_checks++; if (a_fill !== 5'd0) begin n_fail++; $display("FAIL post_reset_a_fill: got %0d expected 0", a_fill); end
    tick();
  endtask

  task automatic test_pack;
    logic [7:0] bytes [4];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in_data = bytes[i];
      tick();
    end
    a_in_valid = 1'b0;   // now just after edge N (4th byte accepted)
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL pack_valid_N: got %b expected 0", a_out_valid); end
    tick();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL pack_valid_N1: got %b expected 0", a_out_valid); end
    tick();
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL pack_valid_N2: got %b expected 1", a_out_valid); end
    n_checks++; if (a_out_data !== 32'h44332211) begin n_fail++; $display("FAIL pack_data: got %h expected 44332211", a_out_data); end
    tick();   // hold: out_ready still 0
    n_checks++; if (a_out_data !== 32'h44332211 || a_out_valid !== 1'b1) begin n_fail++; $display("FAIL pack_hold: got %b/%h expected 1/44332211", a_out_valid, a_out_data); end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL pack_drained_valid: got %b expected 0", a_out_valid); end
    n_checks++; if (a_fill !== 5'd0) begin n_fail++; $display("FAIL pack_drained_fill: got %0d expected 0", a_fill); end
  endtask

  task automatic test_unpack;
    logic [7:0] exp_b [4];
    exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    do_reset();
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_data = 32'hA1B2C3D4;
    tick();
    b_in_valid = 1'b0;
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL unpack_valid_N: got %b expected 0", b_out_valid); end
    tick();
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL unpack_valid_N1: got %b expected 0", b_out_valid); end
    tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== exp_b[k]) begin
        n_fail++; $display("FAIL unpack_byte%0d: got %b/%h expected 1/%h", k, b_out_valid, b_out_data, exp_b[k]);
      end
      tick();
    end
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL unpack_end_valid: got %b expected 0", b_out_valid); end
    b_out_ready = 1'b0;
  endtask

  task automatic test_partial;
    do_reset();
    a_out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_in_valid = 1'b1; a_in_data = 8'(i);
      tick();
    end
    a_in_valid = 1'b0;
    repeat (5) tick();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL partial_valid: got %b expected 0", a_out_valid); end
    n_checks++; if (a_fill !== 5'd3) begin n_fail++; $display("FAIL partial_fill: got %0d expected 3", a_fill); end
    a_in_valid = 1'b1; a_in_data = 8'h04;
    tick();
    a_in_valid = 1'b0;
    for (int i = 0; i < 6 && !a_out_valid; i++) tick();
    n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h04030201) begin n_fail++; $display("FAIL partial_word: got %b/%h expected 1/04030201", a_out_valid, a_out_data); end
    tick();
    n_checks++; if (a_fill !== 5'd0) begin n_fail++; $display("FAIL partial_fill_end: got %0d expected 0", a_fill); end
    a_out_ready = 1'b0;
  endtask

  task automatic test_full;
    int nacc;
    logic [7:0] seq;
    do_reset();
    seq = 8'h00;
    for (int r = 0; r < 2; r++) begin
      nacc = 0;
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = seq;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (a_in_ready) begin nacc++; seq++; end
        tick();
        a_in_data = seq;
      end
      a_in_valid = 1'b0;
      // 16 bytes in RAM plus one 4-byte word held in the output register
      n_checks++; if (nacc != 20) begin n_fail++; $display("FAIL full_accepts_r%0d: got %0d expected 20", r, nacc); end
      n_checks++; if (a_fill !== 5'd16) begin n_fail++; $display("FAIL full_fill_r%0d: got %0d expected 16", r, a_fill); end
      n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready_r%0d: got %b expected 0", r, a_in_ready); end
      n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL full_out_valid_r%0d: got %b expected 1", r, a_out_valid); end
      a_out_ready = 1'b1;
      repeat (40) tick();
      n_checks++; if (a_fill !== 5'd0 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain_r%0d: got fill %0d valid %b expected 0/0", r, a_fill, a_out_valid); end
      n_checks++; if (a_q.size() != 0) begin n_fail++; $display("FAIL full_sb_left_r%0d: got %0d expected 0", r, a_q.size()); end
    end
    a_out_ready = 1'b0;
  endtask

  task automatic test_steady;
    do_reset();
    c_out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      c_in_valid = 1'b1; c_in_data = 16'(i * 3 + 7);
      tick();
      n_checks++; if (c_fill !== 5'd1) begin n_fail++; $display("FAIL steady_fill_c%0d: got %0d expected 1", i, c_fill); end
    end
    c_in_valid = 1'b0;
    repeat (6) tick();
    n_checks++; if (c_q.size() != 0 || c_out_valid !== 1'b0) begin n_fail++; $display("FAIL steady_drain: got %0d left valid %b expected 0/0", c_q.size(), c_out_valid); end
    c_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp_b [4];
    exp_b = '{8'h88, 8'h77, 8'h66, 8'h55};
    do_reset();
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_in_valid = 1'b1; a_in_data = 8'($urandom);
      b_in_valid = 1'b1; b_in_data = $urandom;
      c_in_valid = 1'b1; c_in_data = 16'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    n_checks++; if (b_out_valid !== 1'b0 || b_fill !== 5'd0) begin n_fail++; $display("FAIL midrst_b: got valid %b fill %0d expected 0/0", b_out_valid, b_fill); end
    n_checks++; if (a_out_valid !== 1'b0 || a_fill !== 5'd0) begin n_fail++; $display("FAIL midrst_a: got valid %b fill %0d expected 0/0", a_out_valid, a_fill); end
    n_checks++; if (c_out_valid !== 1'b0 || c_fill !== 5'd0) begin n_fail++; $display("FAIL midrst_c: got valid %b fill %0d expected 0/0", c_out_valid, c_fill); end
    repeat (3) tick();
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale: got valid %b expected 0", b_out_valid); end
    b_in_valid = 1'b1; b_in_data = 32'h55667788;
    tick();
    b_in_valid = 1'b0;
    for (int i = 0; i < 6 && !b_out_valid; i++) tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== exp_b[k]) begin
        n_fail++; $display("FAIL midrst_byte%0d: got %b/%h expected 1/%h", k, b_out_valid, b_out_data, exp_b[k]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      a_in_valid = 1'($urandom_range(0, 1)); a_in_data = 8'($urandom);  a_out_ready = 1'($urandom_range(0, 1));
      b_in_valid = 1'($urandom_range(0, 1)); b_in_data = $urandom;      b_out_ready = 1'($urandom_range(0, 1));
      c_in_valid = 1'($urandom_range(0, 1)); c_in_data = 16'($urandom); c_out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    repeat (60) tick();
    n_checks++; if (a_q.size() != 0) begin n_fail++; $display("FAIL rand_a_left: got %0d expected 0", a_q.size()); end
    n_checks++; if (b_q.size() != 0) begin n_fail++; $display("FAIL rand_b_left: got %0d expected 0", b_q.size()); end
    n_checks++; if (c_q.size() != 0) begin n_fail++; $display("FAIL rand_c_left: got %0d expected 0", c_q.size()); end
    // Leftover narrow bytes that never completed a wide word stay in the RAM
    n_checks++; if (a_fill !== 5'(a_cnt)) begin n_fail++; $display("FAIL rand_a_partial: got %0d expected %0d", a_fill, a_cnt); end
    n_checks++; if (b_fill !== 5'd0 || c_fill !== 5'd0) begin n_fail++; $display("FAIL rand_bc_fill: got %0d/%0d expected 0/0", b_fill, c_fill); end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_pack();
    test_unpack();
    test_partial();
    test_full();
    test_steady();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_asym_fifo
`default_nettype wire
